// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
// Holds the controller state encoding and the default widths and limits.
package pipe_ctrl_pkg;

  localparam int REG_W           = 5;
  localparam int ZERO_REG        = 0;
  localparam int MD_TIMEOUT_DFLT = 40;

  typedef enum logic {
    RUN  = 1'b0,
    MDIV = 1'b1
  } md_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detection between the D/X load and the F/D consumer.
// Writes to the zero register never create a dependency.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int HZ_REG_W = pipe_ctrl_pkg::REG_W
) (
  input  logic                dx_is_load,
  input  logic [HZ_REG_W-1:0] dx_rd,
  input  logic [HZ_REG_W-1:0] fd_rs1,
  input  logic [HZ_REG_W-1:0] fd_rs2,
  input  logic                fd_uses_rs2,
  output logic                stall
);

  logic rd_live;
  logic rs1_hit;
  logic rs2_hit;

  assign rd_live = (dx_rd != HZ_REG_W'(ZERO_REG));
  assign rs1_hit = (dx_rd == fd_rs1);
  assign rs2_hit = fd_uses_rs2 && (dx_rd == fd_rs2);
  assign stall   = dx_is_load && rd_live && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Drives latch-bank enables/clears: load-use bubbles, branch flushes, mult/div freeze.
// Outputs are Mealy from registered state; everything forced to stall/clear while clr_n is low.
module pipe_stall_ctrl #(
  parameter int REG_W      = pipe_ctrl_pkg::REG_W,
  parameter int MD_TIMEOUT = pipe_ctrl_pkg::MD_TIMEOUT_DFLT
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             dx_is_load,
  input  logic [REG_W-1:0] dx_rd,
  input  logic [REG_W-1:0] fd_rs1,
  input  logic [REG_W-1:0] fd_rs2,
  input  logic             fd_uses_rs2,
  input  logic             x_branch_taken,
  input  logic             x_md_start,
  input  logic             md_result_rdy,
  output logic             pc_en,
  output logic             fd_en,
  output logic             dx_en,
  output logic             xm_en,
  output logic             mw_en,
  output logic             fd_clr,
  output logic             dx_clr,
  output logic             xm_clr,
  output logic             md_busy,
  output logic             md_timeout,
  output logic [31:0]      stall_cnt
);
  import pipe_ctrl_pkg::*;

  localparam int CNT_W = (MD_TIMEOUT < 2) ? 1 : $clog2(MD_TIMEOUT + 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic [31:0]      stall_q, stall_d;

  logic lu_stall;
  logic pc_en_r, fd_en_r, dx_en_r, xm_en_r, mw_en_r;
  logic fd_clr_r, dx_clr_r, xm_clr_r;

  hazard_detect #(
    .HZ_REG_W(REG_W)
  ) u_hazard_detect (
    .dx_is_load (dx_is_load),
    .dx_rd      (dx_rd),
    .fd_rs1     (fd_rs1),
    .fd_rs2     (fd_rs2),
    .fd_uses_rs2(fd_uses_rs2),
    .stall      (lu_stall)
  );

  always_comb begin
    pc_en_r  = 1'b1;
    fd_en_r  = 1'b1;
    dx_en_r  = 1'b1;
    xm_en_r  = 1'b1;
    mw_en_r  = 1'b1;
    fd_clr_r = 1'b0;
    dx_clr_r = 1'b0;
    xm_clr_r = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;

    if (state_q == MDIV) begin
      if (md_result_rdy) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        pc_en_r  = 1'b0;
        fd_en_r  = 1'b0;
        dx_en_r  = 1'b0;
        xm_en_r  = 1'b0;
        xm_clr_r = 1'b1;
        // The counter holds the index of the current MDIV cycle, so the last allowed one abandons.
        if (cnt_q >= CNT_W'(MD_TIMEOUT)) begin
          tmo_d   = 1'b1;
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end else begin
      if (x_md_start) begin
        if (!md_result_rdy) begin
          pc_en_r  = 1'b0;
          fd_en_r  = 1'b0;
          dx_en_r  = 1'b0;
          xm_en_r  = 1'b0;
          xm_clr_r = 1'b1;
          state_d  = MDIV;
          cnt_d    = CNT_W'(1);
        end
      end else if (x_branch_taken) begin
        fd_clr_r = 1'b1;
        dx_clr_r = 1'b1;
      end else if (lu_stall) begin
        pc_en_r  = 1'b0;
        fd_en_r  = 1'b0;
        dx_clr_r = 1'b1;
      end
    end
  end

  assign stall_d = (!pc_en_r && !(&stall_q)) ? stall_q + 32'd1 : stall_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      stall_q <= stall_d;
    end
  end

  assign pc_en      = clr_n & pc_en_r;
  assign fd_en      = clr_n & fd_en_r;
  assign dx_en      = clr_n & dx_en_r;
  assign xm_en      = clr_n & xm_en_r;
  assign mw_en      = clr_n & mw_en_r;
  assign fd_clr     = ~clr_n | fd_clr_r;
  assign dx_clr     = ~clr_n | dx_clr_r;
  assign xm_clr     = ~clr_n | xm_clr_r;
  assign md_busy    = clr_n & (state_q == MDIV);
  assign md_timeout = tmo_q;
  assign stall_cnt  = stall_q;

endmodule
